// File: rtl/intel_vvp_remosaic_cpu_regbank_if.sv
// Avalon-MM agent bundle for the Remosaic CPU register bank.
// The CPU side drives through the master modport and the register bank sits on the slave modport.
interface intel_vvp_remosaic_cpu_regbank_if #(
    parameter int unsigned C_ADDR_WIDTH = 6
);
    logic [C_ADDR_WIDTH-1:0] av_address;
    logic                    av_read;
    logic [31:0]             av_readdata;
    logic                    av_readdatavalid;
    logic                    av_waitrequest;
    logic                    av_write;
    logic [31:0]             av_writedata;
    logic [3:0]              av_byteenable;

    modport master (
        output av_address, av_read, av_write, av_writedata, av_byteenable,
        input  av_readdata, av_readdatavalid, av_waitrequest
    );

    modport slave (
        input  av_address, av_read, av_write, av_writedata, av_byteenable,
        output av_readdata, av_readdatavalid, av_waitrequest
    );
endinterface

// File: rtl/intel_vvp_remosaic_cpu_regbank.sv
// Remosaic CPU register bank: shadow configuration registers that are copied
// to the video-facing active set only at a committed frame boundary.
// Optional macro INTEL_VVP_REMOSAIC_REGBANK_IRQ_EN adds the irq output,
// the IRQ_EN register and the STATUS.irq_stat bit.
module intel_vvp_remosaic_cpu_regbank #(
    parameter int unsigned C_CPU_OFFSET = 0,
    parameter int unsigned C_ADDR_WIDTH = 6,
    parameter int unsigned C_NUM_CFG    = 4,
    parameter int unsigned C_CFG_WIDTH  = 8,
    parameter logic [C_NUM_CFG*C_CFG_WIDTH-1:0] C_CFG_RESET = {C_NUM_CFG{8'b00010110}},
    parameter logic [31:0] C_VERSION    = 32'hBEEF_F00D
) (
    input  logic                             main_clock,
    input  logic                             main_reset,
    intel_vvp_remosaic_cpu_regbank_if.slave  av,
    input  logic                             vid_sof,
    output logic                             vid_go,
    output logic [C_NUM_CFG*C_CFG_WIDTH-1:0] vid_cfg,
    output logic                             vid_cfg_update
`ifdef INTEL_VVP_REMOSAIC_REGBANK_IRQ_EN
    ,
    output logic                             irq
`endif
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // Registered bus inputs
    logic                    rd_q;
    logic                    wr_q;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              be_q;

    // Decode
    logic [31:0]          rel_s;
    logic                 in_map_s;
    logic [C_NUM_CFG-1:0] cfg_hit_s;
    logic [31:0]          cfg_rd_s;
    logic [31:0]          wmask_s;
    logic [31:0]          rdata_s;

    // State
    logic [0:0]                       state_r;
    logic [0:0]                       state_nxt_s;
    logic                             go_r;
    logic                             go_nxt_s;
    logic                             pending_s;
    logic                             ctrl_wr_s;
    logic                             commit_req_s;
    logic                             apply_s;
    logic [C_NUM_CFG*C_CFG_WIDTH-1:0] shadow_r;
    logic [C_NUM_CFG*C_CFG_WIDTH-1:0] active_r;
    logic                             update_r;
    logic [31:0]                      readdata_r;
    logic                             rdvalid_r;
    logic                             waitreq_r;
    logic                             irq_stat_rd_s;
    logic                             irq_en_rd_s;

    // Capture the Avalon request once; all register effects follow one edge later
    always_ff @(posedge main_clock) begin
        if (main_reset) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            be_q    <= 4'b0000;
        end else begin
            rd_q    <= av.av_read;
            wr_q    <= av.av_write;
            addr_q  <= av.av_address;
            wdata_q <= av.av_writedata;
            be_q    <= av.av_byteenable;
        end
    end

    // Address decode relative to the CPU offset, plus byte-lane mask and shadow readback
    always_comb begin
        rel_s    = 32'(addr_q) - C_CPU_OFFSET;
        in_map_s = (32'(addr_q) >= C_CPU_OFFSET);
        wmask_s  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
        cfg_rd_s = 32'h0000_0000;
        for (int k = 0; k < C_NUM_CFG; k++) begin
            cfg_hit_s[k] = in_map_s && (rel_s == (32'(k) + 32'd4));
            cfg_rd_s     = cfg_rd_s |
                           (cfg_hit_s[k] ? 32'(shadow_r[k*C_CFG_WIDTH +: C_CFG_WIDTH]) : 32'h0000_0000);
        end
    end

    // Read data multiplexer; unmapped words return a fixed marker
    always_comb begin
        if (!in_map_s) begin
            rdata_s = 32'h1234_ABCD;
        end else begin
            case (rel_s)
                32'd0:   rdata_s = C_VERSION;
                32'd1:   rdata_s = {30'd0, pending_s, go_r};
                32'd2:   rdata_s = {29'd0, irq_stat_rd_s, pending_s, go_r};
                32'd3:   rdata_s = {31'd0, irq_en_rd_s};
                default: rdata_s = (|cfg_hit_s) ? cfg_rd_s : 32'h1234_ABCD;
            endcase
        end
    end

    // Commit state machine: decides when the shadow set is copied to the active set
    always_comb begin
        pending_s    = (state_r == ST_PENDING);
        ctrl_wr_s    = wr_q && in_map_s && (rel_s == 32'd1) && be_q[0];
        go_nxt_s     = ctrl_wr_s ? wdata_q[0] : go_r;
        commit_req_s = ctrl_wr_s && wdata_q[1];
        apply_s      = 1'b0;
        state_nxt_s  = state_r;
        case (state_r)
            ST_IDLE: begin
                if (commit_req_s && go_nxt_s) begin
                    state_nxt_s = ST_PENDING;
                end else if (commit_req_s) begin
                    apply_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // Frame start, or GO being dropped, releases the pending commit
                if (vid_sof || !go_nxt_s) begin
                    apply_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Register file, apply path and Avalon response registers
    always_ff @(posedge main_clock) begin
        if (main_reset) begin
            state_r    <= ST_IDLE;
            go_r       <= 1'b0;
            shadow_r   <= C_CFG_RESET;
            active_r   <= C_CFG_RESET;
            update_r   <= 1'b0;
            readdata_r <= 32'h0000_0000;
            rdvalid_r  <= 1'b0;
            waitreq_r  <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            go_r      <= go_nxt_s;
            update_r  <= apply_s;
            rdvalid_r <= rd_q;
            waitreq_r <= 1'b0;
            if (rd_q) begin
                readdata_r <= rdata_s;
            end
            // Active takes the shadow value as it was before any write on this edge
            if (apply_s) begin
                active_r <= shadow_r;
            end
            for (int k = 0; k < C_NUM_CFG; k++) begin
                if (wr_q && cfg_hit_s[k]) begin
                    shadow_r[k*C_CFG_WIDTH +: C_CFG_WIDTH] <= C_CFG_WIDTH'(
                        (32'(shadow_r[k*C_CFG_WIDTH +: C_CFG_WIDTH]) & ~wmask_s) |
                        (wdata_q & wmask_s));
                end
            end
        end
    end

`ifdef INTEL_VVP_REMOSAIC_REGBANK_IRQ_EN
    logic irq_stat_r;
    logic irq_en_r;
    logic irq_r;
    logic irq_set_s;
    logic irq_clr_s;
    logic irq_stat_nxt_s;
    logic irq_en_nxt_s;

    // Frame-boundary interrupt status (set wins over W1C) and enable
    always_comb begin
        irq_set_s      = pending_s && vid_sof;
        irq_clr_s      = wr_q && in_map_s && (rel_s == 32'd2) && be_q[0] && wdata_q[2];
        irq_stat_nxt_s = irq_set_s || (irq_stat_r && !irq_clr_s);
        irq_en_nxt_s   = (wr_q && in_map_s && (rel_s == 32'd3) && be_q[0]) ? wdata_q[0] : irq_en_r;
    end

    // Interrupt registers; irq tracks the status and enable values being loaded
    always_ff @(posedge main_clock) begin
        if (main_reset) begin
            irq_stat_r <= 1'b0;
            irq_en_r   <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            irq_stat_r <= irq_stat_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            irq_r      <= irq_stat_nxt_s && irq_en_nxt_s;
        end
    end

    assign irq           = irq_r;
    assign irq_stat_rd_s = irq_stat_r;
    assign irq_en_rd_s   = irq_en_r;
`else
    assign irq_stat_rd_s = 1'b0;
    assign irq_en_rd_s   = 1'b0;
`endif

    assign av.av_readdata      = readdata_r;
    assign av.av_readdatavalid = rdvalid_r;
    assign av.av_waitrequest   = waitreq_r;
    assign vid_go              = go_r;
    assign vid_cfg             = active_r;
    assign vid_cfg_update      = update_r;

endmodule
